// File: rtl/pio_share_arbiter_if.sv
// Bus bundle between the two data producers, the CPU-facing PIO lines and
// pio_share_arbiter.
//   master : producers + CPU side (drives requests and cpu_ack, observes status)
//   slave  : arbiter side (takes requests, drives acks, holding register, status)
// Signals:
//   req0_data/req0_valid/req0_ack : requester 0 word, valid, one-cycle taken pulse
//   req1_data/req1_valid/req1_ack : requester 1 word, valid, one-cycle taken pulse
//   cpu_ack      : level from output PIO bit, rising edge = word read
//   pio_data     : holding register feeding the PIO in_port
//   data_ready   : holding register valid and awaiting the CPU
//   src_id       : requester that supplied pio_data
//   timeout_flag : sticky, last word dropped by timeout
//   word_count   : words acknowledged by the CPU, wrapping
interface pio_share_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic [DATA_W-1:0] req0_data;
    logic              req0_valid;
    logic              req0_ack;
    logic [DATA_W-1:0] req1_data;
    logic              req1_valid;
    logic              req1_ack;
    logic              cpu_ack;
    logic [DATA_W-1:0] pio_data;
    logic              data_ready;
    logic              src_id;
    logic              timeout_flag;
    logic [CNT_W-1:0]  word_count;

    modport master (
        output req0_data, req0_valid, req1_data, req1_valid, cpu_ack,
        input  req0_ack, req1_ack, pio_data, data_ready, src_id, timeout_flag, word_count
    );

    modport slave (
        input  req0_data, req0_valid, req1_data, req1_valid, cpu_ack,
        output req0_ack, req1_ack, pio_data, data_ready, src_id, timeout_flag, word_count
    );
endinterface

// File: rtl/pio_share_arbiter.sv
// Shares one Avalon PIO input register between two data producers.
// Round-robin arbitration latches the winning word into a holding register
// that drives the PIO in_port and holds it until the CPU acknowledges with a
// rising edge on cpu_ack, or until TIMEOUT_CYCLES elapse (0 = never).
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : pio_share_arbiter_if.slave (requests, acks, cpu_ack, status)
module pio_share_arbiter #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned CNT_W          = 16
) (
    input logic                clk,
    input logic                reset_n,
    pio_share_arbiter_if.slave bus
);

    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Only meaningful when TIMEOUT_CYCLES != 0; the compare is gated on that.
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StRelease
    } state_e;

    state_e            state_q;
    logic              rr_last_q;
    logic              cpu_ack_d;
    logic [TmoW-1:0]   tmo_cnt_q;
    logic [DATA_W-1:0] pio_data_q;
    logic              data_ready_q;
    logic              src_id_q;
    logic              timeout_flag_q;
    logic [CNT_W-1:0]  word_count_q;
    logic              req0_ack_q;
    logic              req1_ack_q;

    logic ack_edge;
    logic grant_any;
    logic grant_id;

    // Edge is tracked in every state so a rise seen outside WAIT is consumed.
    assign ack_edge = bus.cpu_ack & ~cpu_ack_d;

    // Prefer the requester that did not win last; otherwise take whichever is valid.
    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        if (rr_last_q) begin
            grant_id = bus.req0_valid ? 1'b0 : 1'b1;
        end else begin
            grant_id = bus.req1_valid ? 1'b1 : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            rr_last_q      <= 1'b1;
            cpu_ack_d      <= 1'b0;
            tmo_cnt_q      <= '0;
            pio_data_q     <= '0;
            data_ready_q   <= 1'b0;
            src_id_q       <= 1'b0;
            timeout_flag_q <= 1'b0;
            word_count_q   <= '0;
            req0_ack_q     <= 1'b0;
            req1_ack_q     <= 1'b0;
        end else begin
            cpu_ack_d  <= bus.cpu_ack;
            req0_ack_q <= 1'b0;
            req1_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        pio_data_q   <= grant_id ? bus.req1_data : bus.req0_data;
                        src_id_q     <= grant_id;
                        rr_last_q    <= grant_id;
                        req0_ack_q   <= ~grant_id;
                        req1_ack_q   <= grant_id;
                        data_ready_q <= 1'b1;
                        tmo_cnt_q    <= '0;
                        state_q      <= StWait;
                    end
                end
                StWait: begin
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    if (ack_edge) begin
                        word_count_q   <= word_count_q + 1'b1;
                        timeout_flag_q <= 1'b0;
                        data_ready_q   <= 1'b0;
                        state_q        <= StRelease;
                    end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TmoLast)) begin
                        timeout_flag_q <= 1'b1;
                        data_ready_q   <= 1'b0;
                        state_q        <= StRelease;
                    end
                end
                StRelease: begin
                    // One ready-low cycle so the CPU always sees ready fall.
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.pio_data     = pio_data_q;
    assign bus.data_ready   = data_ready_q;
    assign bus.src_id       = src_id_q;
    assign bus.timeout_flag = timeout_flag_q;
    assign bus.word_count   = word_count_q;
    assign bus.req0_ack     = req0_ack_q;
    assign bus.req1_ack     = req1_ack_q;

endmodule
